cplx_interp: RTL and testbench
==============================

# cplx_interp

Dual-channel (I/Q) linear interpolator for the transmit path, the expanding counterpart to our rounding/saturating narrowing stage. It accepts narrow signed complex samples at the baseband rate and emits 2^LOG2_R linearly interpolated samples per input, each LOG2_R bits wider. Widening is exact, so the block never needs saturation or rounding. It sits between the baseband sample source and the upconversion/DAC-rate logic, with ready/valid handshakes on both sides.

## Interface
- IN_SIZE, 16: input sample width, signed two's complement.
- LOG2_R, 3: log2 of the interpolation factor R. Must be at least 1.
- OUT_SIZE (localparam) = IN_SIZE + LOG2_R: output width.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an input sample is presented.
- in_ready  out  1  the block accepts a sample this cycle.
- d1  in  IN_SIZE  channel 1 (I) input, signed.
- d2  in  IN_SIZE  channel 2 (Q) input, signed.
- out_valid  out  1  q1/q2 hold a valid output.
- out_ready  in  1  the downstream consumer takes the output this cycle.
- q1  out  OUT_SIZE  channel 1 output, signed, registered.
- q2  out  OUT_SIZE  channel 2 output, signed, registered.

## Operation
- State per channel:
  - prev (IN_SIZE): last completed sample; resets to 0.
  - delta (IN_SIZE+1): cur − prev, which never overflows.
  - acc (OUT_SIZE): drives q.
- Shared state: phase counter (LOG2_R bits) and the FSM.
- FSM has two states, IDLE and EMIT; reset enters IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept (in_valid & in_ready): delta ← d − prev, acc ← prev<<LOG2_R, cur ← d, phase ← 0, go to EMIT.
- EMIT:
  - out_valid=1, q=acc.
  - On out_ready with phase≠R−1: acc ← acc+delta, phase ← phase+1.
- Last phase (phase=R−1, out_ready=1):
  - prev ← cur, and in_ready=1 in this same cycle.
  - If in_valid=1: reload exactly as on an IDLE accept, using the updated prev (= cur) for the new delta and acc, and stay in EMIT.
  - If in_valid=0: go to IDLE.
- in_ready = (state==IDLE) | (state==EMIT & phase==R−1 & out_ready). This is the only combinational path from out_ready to in_ready.
- Output sequence for inputs prev→cur: prev·R + k·delta for k=0..R−1. The next segment starts at cur·R, so the output is continuous across segment boundaries.
- Arithmetic: all values are signed. Every intermediate acc lies between prev·R and cur·R, so OUT_SIZE bits always suffice with no wrap.
- Both channels share the FSM and phase and advance in lockstep.

## Timing
- Latency: a sample accepted at edge t appears on q at t+1 (first interpolated point).
- Throughput: one input per R cycles when out_ready is held at 1, with no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, q1/q2, acc, and phase hold unchanged, and in_ready=0.
- An input presented while in_ready=0 is not taken; the upstream source must hold it.
- Reset values: in_ready=1, out_valid=0, q1=q2=0, prev=0, phase=0.
- Reset mid-EMIT: the in-flight segment is discarded and the next input interpolates from 0.
- R=2 (LOG2_R=1) is the minimum legal configuration, and the phase counter wraps exactly at R−1.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, EMIT);
  - a width helper function computing OUT_SIZE and the delta width from IN_SIZE and LOG2_R.
- Sub-module interp_lane: one channel's datapath (prev, cur, delta, acc, load/step controls), instantiated twice.
- The top level owns the FSM, phase counter, and handshake logic.

## Test plan
- Ramp, LOG2_R=2, IN_SIZE=16, out_ready=1: inputs 100 then 100 → q1 outputs 0,100,200,300,400,400,400,400; first out_valid one cycle after the first accept.
- Sign crossing, same configuration: prev=100, input −100 → q1 outputs 400,200,0,−200.
- Extremes: prev=32767, input −32768 (LOG2_R=2) → outputs 131068, 65533, −2, −65537, with no wrap. The next input −32768 → constant −131072 for four outputs.
- Backpressure: toggle out_ready pseudo-randomly during a segment → q sequence identical to the stall-free run, q stable while stalled, in_ready high only at the last-phase handshake or in IDLE.
- Back-to-back: in_valid held high, out_ready=1 → in_ready pulses every R cycles, out_valid stays continuously 1, and no sample is lost or duplicated.
- Reset mid-segment: assert rst at phase 1 → next cycle out_valid=0, q=0, in_ready=1. The next input 8 (LOG2_R=2) → outputs 0,8,16,24.

Source files
------------

// File: rtl/cplx_interp_pkg.sv
// Shared types and width helpers for the complex linear interpolator.
package cplx_interp_pkg;

    // Controller states: waiting for a sample, or emitting interpolated points.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Output width: exact widening by the interpolation factor.
    function automatic int out_width(input int in_size, input int log2_r);
        return in_size + log2_r;
    endfunction

    // Difference of two IN_SIZE samples needs one extra bit.
    function automatic int delta_width(input int in_size);
        return in_size + 1;
    endfunction

endpackage

// File: rtl/cplx_interp_lane.sv
// One channel of the interpolator: holds prev/cur, the segment slope and the
// running accumulator that drives the registered output.
module cplx_interp_lane
    import cplx_interp_pkg::*;
#(
    parameter int IN_SIZE = 16,
    parameter int LOG2_R  = 3,
    localparam int OUT_SIZE = out_width(IN_SIZE, LOG2_R),
    localparam int DLT_SIZE = delta_width(IN_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic                       commit,
    input  logic signed [IN_SIZE-1:0]  d,
    output logic signed [OUT_SIZE-1:0] q
);

    logic signed [IN_SIZE-1:0]  prev;
    logic signed [IN_SIZE-1:0]  cur;
    logic signed [DLT_SIZE-1:0] delta;
    logic signed [OUT_SIZE-1:0] acc;

    // On a back-to-back reload the committed cur is the new starting point,
    // so bypass the prev register in that same cycle.
    logic signed [IN_SIZE-1:0]  base_smp;
    logic signed [OUT_SIZE-1:0] base_acc;
    logic signed [OUT_SIZE-1:0] delta_ext;

    assign base_smp  = commit ? cur : prev;
    assign base_acc  = {base_smp, {LOG2_R{1'b0}}};
    assign delta_ext = OUT_SIZE'(delta);
    assign q         = acc;

    // prev and acc are architecturally visible after reset; cur/delta are
    // always written by a load before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            acc  <= '0;
        end else begin
            if (commit)
                prev <= cur;
            if (load)
                acc <= base_acc;
            else if (step)
                acc <= acc + delta_ext;
        end
    end

    // Segment slope and endpoint capture.
    always_ff @(posedge clk) begin
        if (load) begin
            cur   <= d;
            delta <= DLT_SIZE'(d) - DLT_SIZE'(base_smp);
        end
    end

endmodule

// File: rtl/cplx_interp.sv
// Dual-channel I/Q linear interpolator by 2^LOG2_R with ready/valid on both
// sides. Owns the shared FSM, phase counter and handshake logic.
module cplx_interp
    import cplx_interp_pkg::*;
#(
    parameter int IN_SIZE = 16,
    parameter int LOG2_R  = 3,
    localparam int OUT_SIZE = out_width(IN_SIZE, LOG2_R)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_SIZE-1:0]  d1,
    input  logic signed [IN_SIZE-1:0]  d2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_SIZE-1:0] q1,
    output logic signed [OUT_SIZE-1:0] q2
);

    state_t            state, state_nxt;
    logic [LOG2_R-1:0] phase;
    logic              last_phase;
    logic              load, step, commit;

    assign last_phase = &phase;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake/datapath controls.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_phase) begin
                        commit   = 1'b1;
                        in_ready = 1'b1;
                        if (in_valid)
                            load = 1'b1;
                        else
                            state_nxt = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counter: restarts on every load, advances on each non-final handshake.
    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (load)
            phase <= '0;
        else if (step)
            phase <= phase + LOG2_R'(1);
    end

    cplx_interp_lane #(.IN_SIZE(IN_SIZE), .LOG2_R(LOG2_R)) u_lane_i (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .commit (commit),
        .d      (d1),
        .q      (q1)
    );

    cplx_interp_lane #(.IN_SIZE(IN_SIZE), .LOG2_R(LOG2_R)) u_lane_q (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .commit (commit),
        .d      (d2),
        .q      (q2)
    );

endmodule

// File: tb/tb_cplx_interp.sv
// Self-checking bench for cplx_interp with LOG2_R=2, IN_SIZE=16.
module tb_cplx_interp;

    localparam int IN = 16;
    localparam int L  = 2;
    localparam int R  = 1 << L;
    localparam int OW = IN + L;
    localparam int BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IN-1:0] d1, d2;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] q1, q2;

    int total = 0;
    int bad   = 0;

    int in_q1[$], in_q2[$];
    int obs1[$], obs2[$];
    int exp1[$], exp2[$];
    int mprev1, mprev2;
    int viol_rdy, viol_hold, gaps, accept_cyc, first_out_cyc;

    always #5 clk = ~clk;

    cplx_interp #(.IN_SIZE(IN), .LOG2_R(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d1        (d1),
        .d2        (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q1        (q1),
        .q2        (q2)
    );

    // Reference: each input cur after prev yields prev*R + k*(cur-prev), k=0..R-1.
    task automatic build_expected();
        exp1.delete();
        exp2.delete();
        foreach (in_q1[i]) begin
            for (int k = 0; k < R; k++) begin
                exp1.push_back(mprev1 * R + k * (in_q1[i] - mprev1));
                exp2.push_back(mprev2 * R + k * (in_q2[i] - mprev2));
            end
            mprev1 = in_q1[i];
            mprev2 = in_q2[i];
        end
    endtask

    function automatic int rnd_smp();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d1 = '0; d2 = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mprev1 = 0;
        mprev2 = 0;
    endtask

    // Drives in_q1/in_q2 into the DUT, collecting outputs and protocol observations.
    task automatic run_stream(input int ready_pct);
        int  idx, n, taken, cyc;
        bit  done, started, stall_prev, acc_now, exp_rdy;
        logic signed [OW-1:0] q1_prev, q2_prev;
        idx = 0; n = in_q1.size(); taken = 0; cyc = 0;
        done = 0; started = 0; stall_prev = 0;
        q1_prev = '0; q2_prev = '0;
        obs1.delete(); obs2.delete();
        viol_rdy = 0; viol_hold = 0; gaps = 0; accept_cyc = -1; first_out_cyc = -1;
        while (!done) begin
            in_valid  = (idx < n);
            d1        = (idx < n) ? IN'(in_q1[idx]) : '0;
            d2        = (idx < n) ? IN'(in_q2[idx]) : '0;
            out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (stall_prev && (out_valid !== 1'b1 || q1 !== q1_prev || q2 !== q2_prev))
                viol_hold++;
            exp_rdy = (out_valid !== 1'b1) ? 1'b1 : (out_ready && (taken % R == R - 1));
            if (in_ready !== exp_rdy)
                viol_rdy++;
            if (out_valid === 1'b1) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                started = 1;
            end
            if (started && idx < n && out_valid !== 1'b1)
                gaps++;
            if (out_valid === 1'b1 && out_ready) begin
                obs1.push_back(int'(q1));
                obs2.push_back(int'(q2));
                taken++;
            end
            acc_now = in_valid && (in_ready === 1'b1);
            if (acc_now) begin
                if (accept_cyc < 0) accept_cyc = cyc;
                idx++;
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            q1_prev = q1;
            q2_prev = q2;
            if (idx == n && out_valid !== 1'b1 && !acc_now)
                done = 1;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!done && cyc > BUDGET) begin
                total++; bad++;
                $display("FAIL stream_timeout: accepted=%0d of %0d, outputs=%0d", idx, n, taken);
                done = 1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (q1 !== '0) begin bad++; $display("FAIL reset_q1: got %0d want 0", q1); end
        total++; if (q2 !== '0) begin bad++; $display("FAIL reset_q2: got %0d want 0", q2); end
    endtask

    task automatic test_ramp();
        int lit[8] = '{0, 100, 200, 300, 400, 400, 400, 400};
        do_reset();
        in_q1 = '{100, 100};
        in_q2 = '{rnd_smp(), rnd_smp()};
        build_expected();
        run_stream(100);
        total++; if (obs1.size() != 8) begin bad++; $display("FAIL ramp_count: got %0d want 8", obs1.size()); end
        for (int i = 0; i < 8 && i < obs1.size(); i++) begin
            total++; if (obs1[i] != lit[i]) begin bad++; $display("FAIL ramp_q1[%0d]: got %0d want %0d", i, obs1[i], lit[i]); end
            total++; if (obs2[i] != exp2[i]) begin bad++; $display("FAIL ramp_q2[%0d]: got %0d want %0d", i, obs2[i], exp2[i]); end
        end
        total++; if (first_out_cyc - accept_cyc != 1) begin bad++; $display("FAIL ramp_latency: got %0d want 1", first_out_cyc - accept_cyc); end
        total++; if (viol_rdy != 0) begin bad++; $display("FAIL ramp_in_ready: got %0d bad cycles want 0", viol_rdy); end
    endtask

    task automatic test_sign_cross();
        int lit[4] = '{400, 200, 0, -200};
        in_q1 = '{-100};
        in_q2 = '{rnd_smp()};
        build_expected();
        run_stream(100);
        total++; if (obs1.size() != 4) begin bad++; $display("FAIL sign_count: got %0d want 4", obs1.size()); end
        for (int i = 0; i < 4 && i < obs1.size(); i++) begin
            total++; if (obs1[i] != lit[i]) begin bad++; $display("FAIL sign_q1[%0d]: got %0d want %0d", i, obs1[i], lit[i]); end
            total++; if (obs2[i] != exp2[i]) begin bad++; $display("FAIL sign_q2[%0d]: got %0d want %0d", i, obs2[i], exp2[i]); end
        end
    endtask

    task automatic test_extremes();
        int lit[8] = '{131068, 65533, -2, -65537, -131072, -131072, -131072, -131072};
        do_reset();
        in_q1 = '{32767, -32768, -32768};
        in_q2 = '{-32768, 32767, 32767};
        build_expected();
        run_stream(100);
        total++; if (obs1.size() != 12) begin bad++; $display("FAIL ext_count: got %0d want 12", obs1.size()); end
        for (int i = 0; i < 8 && i + 4 < obs1.size(); i++) begin
            total++; if (obs1[i + 4] != lit[i]) begin bad++; $display("FAIL ext_q1[%0d]: got %0d want %0d", i, obs1[i + 4], lit[i]); end
            total++; if (obs2[i + 4] != exp2[i + 4]) begin bad++; $display("FAIL ext_q2[%0d]: got %0d want %0d", i, obs2[i + 4], exp2[i + 4]); end
        end
    endtask

    task automatic test_backpressure();
        int errs;
        in_q1.delete(); in_q2.delete();
        for (int i = 0; i < 24; i++) begin
            in_q1.push_back(rnd_smp());
            in_q2.push_back(rnd_smp());
        end
        build_expected();
        run_stream(45);
        total++; if (obs1.size() != exp1.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", obs1.size(), exp1.size()); end
        errs = 0;
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            if (obs1[i] != exp1[i] || obs2[i] != exp2[i]) begin
                if (errs < 4) $display("FAIL bp_data[%0d]: got %0d/%0d want %0d/%0d", i, obs1[i], obs2[i], exp1[i], exp2[i]);
                errs++;
            end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_data_total: got %0d wrong samples want 0", errs); end
        total++; if (viol_hold != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable stalls want 0", viol_hold); end
        total++; if (viol_rdy != 0) begin bad++; $display("FAIL bp_in_ready: got %0d bad cycles want 0", viol_rdy); end
    endtask

    task automatic test_back_to_back();
        int errs;
        in_q1.delete(); in_q2.delete();
        for (int i = 0; i < 16; i++) begin
            in_q1.push_back(rnd_smp());
            in_q2.push_back(rnd_smp());
        end
        build_expected();
        run_stream(100);
        total++; if (obs1.size() != exp1.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs1.size(), exp1.size()); end
        errs = 0;
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            if (obs1[i] != exp1[i] || obs2[i] != exp2[i]) begin
                if (errs < 4) $display("FAIL b2b_data[%0d]: got %0d/%0d want %0d/%0d", i, obs1[i], obs2[i], exp1[i], exp2[i]);
                errs++;
            end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_data_total: got %0d wrong samples want 0", errs); end
        total++; if (gaps != 0) begin bad++; $display("FAIL b2b_bubbles: got %0d idle cycles want 0", gaps); end
        total++; if (viol_rdy != 0) begin bad++; $display("FAIL b2b_in_ready: got %0d bad cycles want 0", viol_rdy); end
    endtask

    task automatic test_reset_mid();
        int lit[4] = '{0, 8, 16, 24};
        do_reset();
        in_valid = 1'b1; d1 = IN'(5000); d2 = IN'(-3000); out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        total++; if (q1 !== '0) begin bad++; $display("FAIL rmid_q1: got %0d want 0", q1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        mprev1 = 0; mprev2 = 0;
        in_q1 = '{8};
        in_q2 = '{-8};
        build_expected();
        run_stream(100);
        total++; if (obs1.size() != 4) begin bad++; $display("FAIL rmid_count: got %0d want 4", obs1.size()); end
        for (int i = 0; i < 4 && i < obs1.size(); i++) begin
            total++; if (obs1[i] != lit[i]) begin bad++; $display("FAIL rmid_q1[%0d]: got %0d want %0d", i, obs1[i], lit[i]); end
            total++; if (obs2[i] != exp2[i]) begin bad++; $display("FAIL rmid_q2[%0d]: got %0d want %0d", i, obs2[i], exp2[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d1 = '0; d2 = '0;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_sign_cross();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
